// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing: pixel/line counters, syncs, blanking, frame pulse and frame counter.
// Every output comes straight from a flop; the next-state values are computed ahead so outputs never lag the counters.

module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       hs,
    output logic       vs,
    output logic       blank,
    output logic       frame_start,
    output logic [7:0] frame_count
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FP_START   = 10'(H_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] H_BP_START   = 10'(H_VISIBLE + H_FRONT + H_SYNC);

    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FP_START   = 10'(V_VISIBLE);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] V_BP_START   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    typedef enum logic [1:0] {
        VISIBLE = 2'd0,
        FRONT   = 2'd1,
        SYNC    = 2'd2,
        BACK    = 2'd3
    } region_e;

    region_e    h_state_q, h_state_d;
    region_e    v_state_q, v_state_d;
    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       hs_q, hs_d;
    logic       vs_q, vs_d;
    logic       blank_q, blank_d;
    logic       frame_start_q, frame_start_d;
    logic [7:0] frame_count_q, frame_count_d;
    logic       h_wrap;
    logic       v_wrap;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            h_state_q     <= VISIBLE;
            v_state_q     <= VISIBLE;
            x_q           <= '0;
            y_q           <= '0;
            hs_q          <= 1'b1;
            vs_q          <= 1'b1;
            blank_q       <= 1'b1;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            h_state_q     <= h_state_d;
            v_state_q     <= v_state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            blank_q       <= blank_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    always_comb begin
        h_wrap = (x_q == H_LAST);
        v_wrap = (y_q == V_LAST);

        x_d = h_wrap ? '0 : x_q + 10'd1;
        y_d = y_q;
        if (h_wrap) begin
            y_d = v_wrap ? '0 : y_q + 10'd1;
        end

        // Region transitions key off the count about to be presented, so state and count land together.
        h_state_d = h_state_q;
        case (h_state_q)
            VISIBLE: if (x_d == H_FP_START)   h_state_d = FRONT;
            FRONT:   if (x_d == H_SYNC_START) h_state_d = SYNC;
            SYNC:    if (x_d == H_BP_START)   h_state_d = BACK;
            BACK:    if (x_d == '0)           h_state_d = VISIBLE;
            default:                          h_state_d = VISIBLE;
        endcase

        v_state_d = v_state_q;
        if (h_wrap) begin
            case (v_state_q)
                VISIBLE: if (y_d == V_FP_START)   v_state_d = FRONT;
                FRONT:   if (y_d == V_SYNC_START) v_state_d = SYNC;
                SYNC:    if (y_d == V_BP_START)   v_state_d = BACK;
                BACK:    if (y_d == '0)           v_state_d = VISIBLE;
                default:                          v_state_d = VISIBLE;
            endcase
        end

        hs_d          = (h_state_d != SYNC);
        vs_d          = (v_state_d != SYNC);
        blank_d       = (h_state_d == VISIBLE) && (v_state_d == VISIBLE);
        // Only a genuine wrap of the last pixel of the last line starts a frame; reset alone never does.
        frame_start_d = h_wrap && v_wrap;
        frame_count_d = frame_count_q + {7'd0, frame_start_d};
    end

    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign blank       = blank_q;
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule
